// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle ADD/SUB, shift-add MUL and restoring DIV/MOD, one bit per cycle.
// Define MULTICYCLE_ALU_MAC_EN to add a 2*WIDTH accumulator with MAC (1001) and CLRACC (1010).
module multicycle_alu #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [3:0]         OpCode,
    input  logic [WIDTH-1:0]   InputA,
    input  logic [WIDTH-1:0]   InputB,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] Result,
    output logic [1:0]         Error
);

    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b0101;
    localparam logic [3:0] OP_MUL = 4'b0110;
    localparam logic [3:0] OP_DIV = 4'b0111;
    localparam logic [3:0] OP_MOD = 4'b1000;
`ifdef MULTICYCLE_ALU_MAC_EN
    localparam logic [3:0] OP_MAC = 4'b1001;
    localparam logic [3:0] OP_CLR = 4'b1010;
`endif

    localparam int CW = $clog2(WIDTH + 2) + 1;
    localparam logic [CW-1:0] CNT_ITER = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_MAC  = CW'(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [3:0]           r_op;
    logic [WIDTH-1:0]     r_opa;
    logic [WIDTH-1:0]     r_opb;
    logic [WIDTH-1:0]     r_work;   // multiplier (MUL) or quotient (DIV/MOD)
    logic [WIDTH-1:0]     r_rem;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0]   r_prod;
    logic [CW-1:0]        r_count;
    logic [2*WIDTH-1:0]   r_result;
    logic [1:0]           r_error;

    logic                 w_is_mul;
    logic                 w_is_mac;
    logic                 w_is_div;
    logic                 w_div_zero;
    logic                 w_iter;
    logic                 w_finish;
    logic                 w_sub;
    logic [WIDTH-1:0]     w_addend;
    logic [WIDTH:0]       w_full;
    logic                 w_ovf;
    logic [WIDTH:0]       w_trial;
    logic [2*WIDTH-1:0]   w_result;
    logic [1:0]           w_error;

`ifdef MULTICYCLE_ALU_MAC_EN
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH:0]     w_mac_sum;

    assign w_is_mac  = (r_op == OP_MAC);
    assign w_mac_sum = {1'b0, r_acc} + {1'b0, r_prod};
`else
    assign w_is_mac  = 1'b0;
`endif

    assign w_is_mul   = (r_op == OP_MUL) || w_is_mac;
    assign w_is_div   = (r_op == OP_DIV) || (r_op == OP_MOD);
    assign w_div_zero = w_is_div && (r_opb == '0);
    assign w_iter     = (r_count < CNT_ITER);

    // MAC spends one extra cycle after the last partial product before accumulating.
    always_comb begin
        if (w_is_mac)
            w_finish = (r_count == CNT_MAC);
        else if (w_is_mul || (w_is_div && !w_div_zero))
            w_finish = (r_count == CNT_ITER);
        else
            w_finish = 1'b1;
    end

    // Subtraction as A + ~B + 1; overflow is carry-into-MSB XOR carry-out-of-MSB.
    assign w_sub    = (r_op == OP_SUB);
    assign w_addend = w_sub ? ~r_opb : r_opb;
    assign w_full   = {1'b0, r_opa} + {1'b0, w_addend} + (WIDTH+1)'(w_sub);
    assign w_ovf    = w_full[WIDTH] ^ (w_full[WIDTH-1] ^ r_opa[WIDTH-1] ^ w_addend[WIDTH-1]);

    assign w_trial  = {r_rem, r_work[WIDTH-1]} - {1'b0, r_opb};

    always_comb begin
        w_result = '0;
        w_error  = 2'b00;
        case (r_op)
            OP_ADD, OP_SUB: begin
                w_result = {{WIDTH{w_full[WIDTH-1]}}, w_full[WIDTH-1:0]};
                w_error  = {1'b0, w_ovf};
            end
            OP_MUL: w_result = r_prod;
            OP_DIV: begin
                w_result = w_div_zero ? '0 : {{WIDTH{1'b0}}, r_work};
                w_error  = {w_div_zero, 1'b0};
            end
            OP_MOD: begin
                w_result = w_div_zero ? '0 : {{WIDTH{1'b0}}, r_rem};
                w_error  = {w_div_zero, 1'b0};
            end
`ifdef MULTICYCLE_ALU_MAC_EN
            OP_MAC: begin
                w_result = w_mac_sum[2*WIDTH-1:0];
                w_error  = {1'b0, w_mac_sum[2*WIDTH]};
            end
`endif
            default: ;
        endcase
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values in parallel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // NOTE: default assignment first so no path through this block can infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_finish) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != S_IDLE);
        done = (r_state == S_DONE);
    end

    // NOTE: working registers are reset too, so an aborted operation leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_work   <= '0;
            r_rem    <= '0;
            r_mcand  <= '0;
            r_prod   <= '0;
            r_count  <= '0;
            r_result <= '0;
            r_error  <= 2'b00;
        end else if (r_state == S_IDLE) begin
            if (start) begin
                r_op    <= OpCode;
                r_opa   <= InputA;
                r_opb   <= InputB;
                r_mcand <= {{WIDTH{1'b0}}, InputA};
                r_work  <= ((OpCode == OP_DIV) || (OpCode == OP_MOD)) ? InputA : InputB;
                r_prod  <= '0;
                r_rem   <= '0;
                r_count <= '0;
            end
        end else if (r_state == S_RUN) begin
            if (w_finish) begin
                r_result <= w_result;
                r_error  <= w_error;
            end else begin
                r_count <= r_count + CW'(1);
                if (w_iter && w_is_mul) begin
                    if (r_work[0]) r_prod <= r_prod + r_mcand;
                    r_mcand <= r_mcand << 1;
                    r_work  <= r_work >> 1;
                end
                if (w_iter && w_is_div) begin
                    if (!w_trial[WIDTH]) begin
                        r_rem  <= w_trial[WIDTH-1:0];
                        r_work <= {r_work[WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem  <= {r_rem[WIDTH-2:0], r_work[WIDTH-1]};
                        r_work <= {r_work[WIDTH-2:0], 1'b0};
                    end
                end
            end
        end
    end

`ifdef MULTICYCLE_ALU_MAC_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if ((r_state == S_RUN) && w_finish) begin
            if (w_is_mac)           r_acc <= w_mac_sum[2*WIDTH-1:0];
            else if (r_op == OP_CLR) r_acc <= '0;
        end
    end
`endif

    assign Result = r_result;
    assign Error  = r_error;

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu: stimulus pushes model results, a monitor pops them on done.
// Honours MULTICYCLE_ALU_MAC_EN the same way as the design.
module tb_multicycle_alu;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [3:0]     OpCode = '0;
    logic [W-1:0]   InputA = '0;
    logic [W-1:0]   InputB = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] Result;
    logic [1:0]     Error;

    multicycle_alu #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .OpCode (OpCode),
        .InputA (InputA),
        .InputB (InputB),
        .busy   (busy),
        .done   (done),
        .Result (Result),
        .Error  (Error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2*W-1:0] res;
        logic [1:0]     err;
        int             due;
        logic [3:0]     op;
    } exp_t;

    exp_t           sb[$];
    logic [2*W-1:0] m_acc = '0;
    int             checks = 0;
    int             failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: actual=0x%0h required=0x%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operands.
    function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [2*W-1:0] r, output logic [1:0] e, output int lat);
        int             sa, sb_v, s;
        logic [W-1:0]   t;
        logic [2*W-1:0] p;
        logic [2*W:0]   acc_sum;
        r   = '0;
        e   = 2'b00;
        lat = 1;
        p   = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        case (op)
            4'h4, 4'h5: begin
                sa   = int'($signed(a));
                sb_v = int'($signed(b));
                s    = (op == 4'h4) ? sa + sb_v : sa - sb_v;
                t    = W'(s);
                r    = {{W{t[W-1]}}, t};
                e    = {1'b0, (s > 32767) || (s < -32768)};
            end
            4'h6: begin
                r   = p;
                lat = W + 1;
            end
            4'h7, 4'h8: begin
                if (b == 0) e = 2'b10;
                else begin
                    r   = {{W{1'b0}}, (op == 4'h7) ? a / b : a % b};
                    lat = W + 1;
                end
            end
`ifdef MULTICYCLE_ALU_MAC_EN
            4'h9: begin
                acc_sum = {1'b0, m_acc} + {1'b0, p};
                m_acc   = acc_sum[2*W-1:0];
                r       = m_acc;
                e       = {1'b0, acc_sum[2*W]};
                lat     = W + 2;
            end
            4'hA: m_acc = '0;
`endif
            default: ;
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always begin
        exp_t x;
        @(posedge clk);
        #1;
        if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", done, 1'b0);
            end else begin
                x = sb.pop_front();
                check("done_cycle", cyc, x.due);
                check("result", Result, x.res);
                check("error", Error, x.err);
                check("busy_at_done", busy, 1'b1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        if (busy) check("idle_timeout", busy, 1'b0);
    endtask

    task automatic push_exp(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] r;
        logic [1:0]     e;
        int             lat;
        model(op, a, b, r, e, lat);
        sb.push_back('{res: r, err: e, due: cyc + lat, op: op});
    endtask

    // Returns at #1 after the accepting edge; inputs are scrambled afterwards.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit expect_done);
        wait_idle();
        OpCode = op;
        InputA = a;
        InputB = b;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        if (expect_done) push_exp(op, a, b);
        OpCode = 4'($urandom);
        InputA = W'($urandom);
        InputB = W'($urandom);
    endtask

    initial begin
        logic [3:0]   op;
        logic [W-1:0] a, b;
        int           nb, n;

        repeat (2) tick();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_result", Result, '0);
        check("rst_error", Error, 2'b00);
        rst_n = 1'b1;
        tick();

        issue(4'h4, 16'd100, 16'd150, 1'b1);
        issue(4'h5, 16'd200, 16'd87, 1'b1);
        issue(4'h4, 16'd18500, 16'd21230, 1'b1);
        issue(4'h5, 16'h8000, 16'd1, 1'b1);

        issue(4'h6, 16'd477, 16'd116, 1'b1);
        nb = 0;
        n  = 0;
        while (!done && n < 40) begin
            if (busy) nb++;
            tick();
            n++;
        end
        check("mul_busy_cycles", nb, 17);

        issue(4'h6, 16'd22530, 16'd0, 1'b1);
        issue(4'h6, 16'hFFFF, 16'hFFFF, 1'b1);
        issue(4'h7, 16'd29450, 16'd16450, 1'b1);
        issue(4'h8, 16'd32400, 16'd16200, 1'b1);
        issue(4'h7, 16'd21, 16'd0, 1'b1);
        issue(4'h8, 16'd169, 16'd0, 1'b1);
        issue(4'h7, 16'hFFFF, 16'd1, 1'b1);
        issue(4'h0, 16'd5, 16'd6, 1'b1);
        issue(4'hF, 16'd5, 16'd6, 1'b1);

        // start during RUN must be dropped
        issue(4'h6, 16'd1234, 16'd5678, 1'b1);
        repeat (3) tick();
        OpCode = 4'h4;
        InputA = 16'd7;
        InputB = 16'd9;
        start  = 1'b1;
        tick();
        start  = 1'b0;

        // start held from the done cycle: ignored there, accepted one edge later
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        check("b2b_done_seen", done, 1'b1);
        OpCode = 4'h4;
        InputA = 16'd300;
        InputB = 16'hFFFB;
        start  = 1'b1;
        tick();
        tick();
        start  = 1'b0;
        push_exp(4'h4, 16'd300, 16'hFFFB);

        // reset in the middle of a multiply
        issue(4'h6, 16'd400, 16'd300, 1'b0);
        repeat (5) tick();
        rst_n = 1'b0;
        #2;
        check("abort_result", Result, '0);
        check("abort_error", Error, 2'b00);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        m_acc = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        issue(4'h4, 16'd1, 16'd1, 1'b1);

`ifdef MULTICYCLE_ALU_MAC_EN
        issue(4'hA, 16'd0, 16'd0, 1'b1);
        issue(4'h9, 16'd3, 16'd4, 1'b1);
        issue(4'h9, 16'd5, 16'd6, 1'b1);
        issue(4'hA, 16'd0, 16'd0, 1'b1);
        issue(4'h9, 16'hFFFF, 16'hFFFF, 1'b1);
        issue(4'h9, 16'd2, 16'hFFFF, 1'b1);
        issue(4'h9, 16'd1, 16'd1, 1'b1);
`endif

        repeat (60) begin
`ifdef MULTICYCLE_ALU_MAC_EN
            op = (($urandom_range(0, 3)) != 0) ? 4'(4 + $urandom_range(0, 6)) : 4'($urandom_range(0, 15));
`else
            op = (($urandom_range(0, 3)) != 0) ? 4'(4 + $urandom_range(0, 4)) : 4'($urandom_range(0, 15));
`endif
            a = W'($urandom);
            b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            issue(op, a, b, 1'b1);
        end

        n = 0;
        while (sb.size() > 0 && n < 2000) begin
            tick();
            n++;
        end
        check("scoreboard_drained", sb.size(), 0);
        repeat (20) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width (even, >=4); Result width is 2*WIDTH.
REQ-002 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request pulse, sampled only in IDLE.
REQ-005 SHALL have port OpCode  input  4  0100 ADD, 0101 SUB, 0110 MUL, 0111 DIV, 1000 MOD, others unknown.
REQ-006 SHALL have port InputA  input  WIDTH  first operand.
REQ-007 SHALL have port InputB  input  WIDTH  second operand.
REQ-008 SHALL have port busy  output  1  high from the cycle after acceptance through the done cycle inclusive.
REQ-009 SHALL have port done  output  1  single-cycle completion pulse.
REQ-010 SHALL have port Result  output  2*WIDTH  registered result.
REQ-011 SHALL have port Error  output  2  bit0 add/sub overflow, bit1 divide-by-zero.

Function
REQ-012 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-013 IDLE->RUN on start=1; OpCode, InputA and InputB SHALL be latched at that edge, and later input changes SHALL be ignored.
REQ-014 start in RUN or DONE SHALL be ignored (not queued), and DONE SHALL always return to IDLE.
REQ-015 ADD/SUB SHALL use signed two's complement, with the WIDTH-bit sum sign-extended to 2*WIDTH; Error[0]=carry-into-MSB XOR carry-out-of-MSB.
REQ-016 MUL SHALL be unsigned shift-add, one partial product per cycle, WIDTH iterations, giving a full 2*WIDTH product; Error=00.
REQ-017 DIV/MOD SHALL be unsigned restoring division, one quotient bit per cycle, WIDTH iterations; the WIDTH-bit quotient or remainder SHALL be zero-extended to 2*WIDTH.
REQ-018 DIV/MOD with InputB=0 SHALL skip iteration and give Result=0, Error=10.
REQ-019 Unknown OpCode SHALL give Result=0, Error=00.
REQ-020 Latency: if start is accepted at edge k, done SHALL be high after edge k+1 for ADD, SUB, unknown opcodes and divide-by-zero.
REQ-021 Latency: if start is accepted at edge k, done SHALL be high after edge k+WIDTH+1 for MUL, DIV and MOD.
REQ-022 Result and Error SHALL update at the same edge that raises done and SHALL hold until the next completion.
REQ-023 Error bits SHALL be cleared only for the opcode class they do not apply to; no stale bit SHALL survive a new completion.
REQ-024 Back-to-back: start asserted in the done cycle SHALL be ignored, and start in the following cycle (IDLE) SHALL be accepted.

Reset
REQ-025 When rst_n=0, the block SHALL immediately set state=IDLE, busy=0, done=0, Result=0, Error=00, and clear the iteration counter and working registers.
REQ-026 Reset during RUN SHALL abort the operation with no done pulse, and the first start after rst_n rises SHALL be accepted normally.

Configuration
REQ-027 Macro MULTICYCLE_ALU_MAC_EN SHALL control the multiply-accumulate feature.
REQ-028 With the macro defined, there SHALL be a 2*WIDTH accumulator, reset to 0.
REQ-029 With the macro defined, OpCode 1001 (MAC) SHALL run the MUL datapath and then add the product to the accumulator.
REQ-030 With the macro defined, MAC SHALL take latency WIDTH+2, with Result set to the new accumulator value, which wraps modulo 2^(2*WIDTH).
REQ-031 With the macro defined, Error[0]=1 SHALL flag an unsigned carry out of the accumulator on MAC.
REQ-032 With the macro defined, OpCode 1010 (CLRACC) SHALL clear the accumulator with latency 1, Result=0 and Error=00.
REQ-033 With the macro undefined, 1001 and 1010 SHALL be unknown opcodes, and no accumulator logic SHALL exist.

Verification
REQ-034 ADD 100+150 -> done at k+1, Result=250, Error=00.
REQ-035 SUB 200-87 -> Result=113, Error=00; ADD 18500+21230 -> Result=0xFFFF9B32, Error=01.
REQ-036 MUL 477*116 -> done at exactly k+17, busy high for 17 cycles, Result=55332; MUL 22530*0 -> Result=0.
REQ-037 DIV 29450/16450 -> Result=1; MOD 32400%16200 -> Result=0; DIV 21/0 -> done at k+1, Result=0, Error=10; MOD 169/0 -> Error=10.
REQ-038 MUL started, rst_n pulsed low at cycle k+5 -> no done, outputs zero; then ADD 1+1 -> Result=2 at k'+1; start during RUN -> ignored, first result unaffected.
REQ-039 (MAC_EN) CLRACC, MAC 3*4, MAC 5*6 -> Results 0, 12, 42; MAC with accumulator 0xFFFFFFFF plus 1*1 -> Result=0, Error=01.
